fpu_norm_round: RTL and testbench

Two-stage pipelined normaliser and rounder for the FPU add/sub/mul/div datapaths. It takes a raw significand with guard/round/sticky bits, an optional adder carry-out, and a biased exponent. It then:
- normalises the significand (leading-one detect and shift, or 1-bit right shift on carry);
- rounds in any RISC-V rounding mode;
- renormalises after round carry;
- returns the packed fraction, the exponent and the exception flags.

It is the parametrised, pipelined successor to the combinational normalise-and-find-shift logic. It adds rounding, subnormal clamping, overflow handling and valid/ready flow control.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_norm_round.sv | 187 ++++++++++++++++++
 tb/tb_fpu_norm_round.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, result flag vector and
// the rounding-decision helpers used by the normalise/round pipeline.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef struct packed {
        logic zero;
        logic inexact;
        logic tiny;
        logic overflow;
    } fpu_flags_t;

    // Unknown encodings fall through to round-to-nearest-even.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic g, input logic s, input logic lsb);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (g | s);
            RM_RUP:  return !sign & (g | s);
            RM_RMM:  return g;
            default: return g & (s | lsb);
        endcase
    endfunction

    function automatic logic sat_to_inf(input logic [2:0] rm, input logic sign);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign;
            RM_RUP:  return !sign;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter with full priority over every bit.
module fpu_lzc #(
    parameter int W = 27
) (
    input  logic [W-1:0]         value,
    output logic [$clog2(W)-1:0] count,
    output logic                 all_zero
);

    always_comb begin
        count    = '0;
        all_zero = ~|value;
        for (int unsigned i = 0; i < W; i++) begin
            if (value[i]) count = $clog2(W)'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_norm_round.sv
// Two-stage normalise-and-round pipeline: stage 1 aligns the significand,
// stage 2 rounds, renormalises and saturates; valid/ready between stages.
module fpu_norm_round
    import fpu_pkg::*;
#(
    parameter int MW  = 24,
    parameter int GW  = 3,
    parameter int EW  = 8,
    parameter int SHW = $clog2(MW + GW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MW+GW-1:0]  in_mant,
    input  logic              in_carry,
    input  logic [EW-1:0]     in_exp,
    input  logic              in_sign,
    input  logic [2:0]        in_rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MW-2:0]     out_frac,
    output logic [EW-1:0]     out_exp,
    output logic              out_sign,
    output logic [SHW-1:0]    out_shift,
    output logic              out_zero,
    output logic              out_inexact,
    output logic              out_tiny,
    output logic              out_overflow
);

    localparam int NW = MW + GW;
    localparam logic [EW:0] EXP_MAX = {1'b0, {EW{1'b1}}};

    logic s1_valid, s2_valid, s1_ready, s2_ready;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid;

    // ---------------- stage 1: normalise ----------------
    logic [SHW-1:0] lz;
    logic           mant_zero;
    logic           lz_lt_exp;
    logic [NW-1:0]  n_mant;
    logic [EW:0]    n_exp;
    logic [SHW-1:0] n_shift;
    logic           n_zero, n_tiny;

    fpu_lzc #(.W(NW)) u_lzc (
        .value    (in_mant),
        .count    (lz),
        .all_zero (mant_zero)
    );

    assign lz_lt_exp = 32'(lz) < 32'(in_exp);

    always_comb begin
        n_mant  = '0;
        n_exp   = '0;
        n_shift = '0;
        n_zero  = 1'b0;
        n_tiny  = 1'b0;
        if (in_carry) begin
            n_mant    = {1'b1, in_mant[NW-1:1]};
            n_mant[0] = in_mant[1] | in_mant[0];
            n_exp     = {1'b0, in_exp} + 1'b1;
        end else if (mant_zero) begin
            n_zero = 1'b1;
        end else if (lz_lt_exp) begin
            n_shift = lz;
            n_mant  = in_mant << lz;
            n_exp   = {1'b0, in_exp} - (EW+1)'(lz);
        end else begin
            // Shift only as far as the minimum exponent allows; result stays subnormal.
            n_shift = (in_exp == '0) ? '0 : SHW'(in_exp - 1'b1);
            n_mant  = in_mant << n_shift;
            n_tiny  = 1'b1;
        end
    end

    logic [NW-1:0]  s1_mant;
    logic [EW:0]    s1_exp;
    logic [SHW-1:0] s1_shift;
    logic           s1_zero, s1_tiny, s1_sign;
    logic [2:0]     s1_rm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_shift <= '0;
            s1_zero  <= 1'b0;
            s1_tiny  <= 1'b0;
            s1_sign  <= 1'b0;
            s1_rm    <= '0;
        end else begin
            if (s1_ready) s1_valid <= in_valid;
            if (in_valid && s1_ready) begin
                s1_mant  <= n_mant;
                s1_exp   <= n_exp;
                s1_shift <= n_shift;
                s1_zero  <= n_zero;
                s1_tiny  <= n_tiny;
                s1_sign  <= in_sign;
                s1_rm    <= in_rm;
            end
        end
    end

    // ---------------- stage 2: round ----------------
    logic [MW-1:0] sig;
    logic          g, s, inc, trunc_ovf, ovf;
    logic [MW:0]   sum;
    logic [EW:0]   exp_r;
    logic [MW-2:0] r_frac;
    logic [EW-1:0] r_exp;
    fpu_flags_t    r_flags;

    assign sig = s1_mant[NW-1:GW];
    assign g   = s1_mant[GW-1];
    assign s   = |s1_mant[GW-2:0];
    assign inc = round_inc(s1_rm, s1_sign, g, s, sig[0]);
    assign sum = {1'b0, sig} + (MW+1)'(inc);

    always_comb begin
        r_frac  = sum[MW-2:0];
        r_exp   = '0;
        r_flags = '0;
        if (s1_tiny) begin
            exp_r = sum[MW] ? (EW+1)'(2) : (EW+1)'(sum[MW-1]);
        end else begin
            exp_r = s1_exp + (EW+1)'(sum[MW]);
        end
        // Magnitude beyond max finite while the mode truncates still flags overflow.
        trunc_ovf = !inc && (g || s) && (&sig) && (s1_exp == EXP_MAX - 1'b1);
        ovf       = (exp_r >= EXP_MAX) || trunc_ovf;
        if (s1_zero) begin
            r_frac       = '0;
            r_flags.zero = 1'b1;
        end else if (ovf) begin
            r_flags.overflow = 1'b1;
            r_flags.inexact  = 1'b1;
            if (sat_to_inf(s1_rm, s1_sign)) begin
                r_exp  = '1;
                r_frac = '0;
            end else begin
                r_exp  = {{(EW-1){1'b1}}, 1'b0};
                r_frac = '1;
            end
        end else begin
            r_exp           = exp_r[EW-1:0];
            r_flags.inexact = g | s;
            r_flags.tiny    = s1_tiny && (exp_r == '0);
        end
    end

    fpu_flags_t out_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_frac  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_shift <= '0;
            out_flags <= '0;
        end else begin
            if (s2_ready) s2_valid <= s1_valid;
            if (s1_valid && s2_ready) begin
                out_frac  <= r_frac;
                out_exp   <= r_exp;
                out_sign  <= s1_sign;
                out_shift <= s1_zero ? '0 : s1_shift;
                out_flags <= r_flags;
            end
        end
    end

    assign out_zero     = out_flags.zero;
    assign out_inexact  = out_flags.inexact;
    assign out_tiny     = out_flags.tiny;
    assign out_overflow = out_flags.overflow;

endmodule

// File: tb/tb_fpu_norm_round.sv
// Scoreboard bench for fpu_norm_round: expected results are queued at accept
// and compared when each beat leaves the pipeline.
module tb_fpu_norm_round;
    import fpu_pkg::*;

    localparam int MW  = 24;
    localparam int GW  = 3;
    localparam int EW  = 8;
    localparam int SHW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [MW+GW-1:0]  in_mant = '0;
    logic              in_carry = 1'b0;
    logic [EW-1:0]     in_exp = '0;
    logic              in_sign = 1'b0;
    logic [2:0]        in_rm = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [MW-2:0]     out_frac;
    logic [EW-1:0]     out_exp;
    logic              out_sign;
    logic [SHW-1:0]    out_shift;
    logic              out_zero, out_inexact, out_tiny, out_overflow;

    int checks = 0;
    int errors = 0;

    fpu_norm_round #(.MW(MW), .GW(GW), .EW(EW), .SHW(SHW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mant      (in_mant),
        .in_carry     (in_carry),
        .in_exp       (in_exp),
        .in_sign      (in_sign),
        .in_rm        (in_rm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_frac     (out_frac),
        .out_exp      (out_exp),
        .out_sign     (out_sign),
        .out_shift    (out_shift),
        .out_zero     (out_zero),
        .out_inexact  (out_inexact),
        .out_tiny     (out_tiny),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    // flags order: {zero, inexact, tiny, overflow}
    typedef struct {
        logic [MW+GW-1:0] mant;
        logic             carry;
        logic [EW-1:0]    exp;
        logic             sign;
        logic [2:0]       rm;
        logic [MW-2:0]    e_frac;
        logic [EW-1:0]    e_exp;
        logic [SHW-1:0]   e_shift;
        logic [3:0]       e_flags;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t mon_e;

    task automatic add_vec(input logic [23:0] m, input logic [2:0] x, input logic c,
                           input int e, input logic sg, input logic [2:0] rm,
                           input logic [22:0] f, input int ee, input int sh,
                           input logic [3:0] fl);
        vec_t v;
        v.mant = {m, x}; v.carry = c; v.exp = EW'(e); v.sign = sg; v.rm = rm;
        v.e_frac = f; v.e_exp = EW'(ee); v.e_shift = SHW'(sh); v.e_flags = fl;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        in_mant  = v.mant;
        in_carry = v.carry;
        in_exp   = v.exp;
        in_sign  = v.sign;
        in_rm    = v.rm;
        in_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got frac=%h exp=%0d with empty scoreboard",
                         out_frac, out_exp);
            end else begin
                mon_e = sb.pop_front();
                if ({out_frac, out_exp, out_sign, out_shift,
                     out_zero, out_inexact, out_tiny, out_overflow} !==
                    {mon_e.e_frac, mon_e.e_exp, mon_e.sign, mon_e.e_shift, mon_e.e_flags}) begin
                    errors++;
                    $display("FAIL result mant=%h: got frac=%h exp=%0d sign=%b shift=%0d zito=%b%b%b%b, expected frac=%h exp=%0d sign=%b shift=%0d zito=%b",
                             mon_e.mant, out_frac, out_exp, out_sign, out_shift,
                             out_zero, out_inexact, out_tiny, out_overflow,
                             mon_e.e_frac, mon_e.e_exp, mon_e.sign, mon_e.e_shift, mon_e.e_flags);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #3;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_handshake: got out_valid,in_ready=%b%b, expected 01", out_valid, in_ready);
        end
        checks++;
        if ({out_frac, out_exp, out_sign, out_shift, out_zero, out_inexact, out_tiny, out_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got frac=%h exp=%0d shift=%0d flags=%b%b%b%b, expected all 0",
                     out_frac, out_exp, out_shift, out_zero, out_inexact, out_tiny, out_overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        drive(vecs[0]);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL latency_ready: got in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk); sb.push_back(vecs[0]); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_two: got out_valid=%b two cycles after accept, expected 1", out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        int n;
        out_ready = 1'b1;
        for (int i = 1; i < vecs.size(); i++) begin
            drive(vecs[i]);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (n >= 20) begin
                errors++;
                $display("FAIL accept_timeout vec=%0d: got in_ready=0 for %0d cycles, expected 1", i, n);
            end
            @(posedge clk); sb.push_back(vecs[i]); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_vectors: got %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int pick[4] = '{0, 2, 9, 10};
        logic [MW-2:0] held = '0;
        logic acc;
        int n;
        for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            drive(vecs[pick[idx]]);
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 2) begin
                checks++;
                if ({in_ready, out_valid} !== 2'b01 || idx != 2) begin
                    errors++;
                    $display("FAIL stall_fill: got in_ready=%b out_valid=%b accepted=%0d, expected 0 1 2",
                             in_ready, out_valid, idx);
                end
                held = out_frac;
                checks++;
                if (out_frac !== vecs[pick[0]].e_frac) begin
                    errors++;
                    $display("FAIL stall_head: got frac=%h, expected %h", out_frac, vecs[pick[0]].e_frac);
                end
            end
            if (cyc == 4) begin
                checks++;
                if ({in_ready, out_valid} !== 2'b01 || out_frac !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got in_ready=%b out_valid=%b frac=%h, expected 0 1 %h",
                             in_ready, out_valid, out_frac, held);
                end
            end
            acc = in_ready;
            @(posedge clk);
            if (acc) begin sb.push_back(vecs[pick[idx]]); idx++; end
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL stream_accept: got %0d beats accepted, expected 4", idx);
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_stream: got %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        int n;
        out_ready = 1'b1;
        drive(vecs[2]); @(posedge clk); sb.push_back(vecs[2]); #1;
        drive(vecs[4]); @(posedge clk); sb.push_back(vecs[4]); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midstream_busy: got out_valid=%b, expected 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL midstream_reset: got out_valid,in_ready=%b%b, expected 01", out_valid, in_ready);
        end
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(vecs[9]); @(posedge clk); sb.push_back(vecs[9]); #1;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL restart: got %0d beats outstanding, expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_dup: got out_valid=%b after drain, expected 0", out_valid);
        end
    endtask

    initial begin
        //       mant       grs     c  exp  sg rm        frac          exp  sh  zito
        add_vec(24'h000001, 3'b000, 0, 30,  0, RM_RNE, 23'h000000,   7, 23, 4'b0000); // 0
        add_vec(24'h800001, 3'b000, 1, 10,  0, RM_RNE, 23'h400000,  11,  0, 4'b0100); // 1
        add_vec(24'hFFFFFF, 3'b100, 0, 100, 0, RM_RNE, 23'h000000, 101,  0, 4'b0100); // 2
        add_vec(24'hFFFFFF, 3'b100, 0, 100, 0, RM_RTZ, 23'h7FFFFF, 100,  0, 4'b0100); // 3
        add_vec(24'hFFFFFF, 3'b111, 0, 254, 0, RM_RNE, 23'h000000, 255,  0, 4'b0101); // 4
        add_vec(24'hFFFFFF, 3'b111, 0, 254, 0, RM_RTZ, 23'h7FFFFF, 254,  0, 4'b0101); // 5
        add_vec(24'hFFFFFF, 3'b111, 0, 254, 1, RM_RDN, 23'h000000, 255,  0, 4'b0101); // 6
        add_vec(24'hFFFFFF, 3'b111, 0, 254, 1, RM_RUP, 23'h7FFFFF, 254,  0, 4'b0101); // 7
        add_vec(24'h000000, 3'b000, 0, 77,  0, RM_RNE, 23'h000000,   0,  0, 4'b1000); // 8
        add_vec(24'h000100, 3'b000, 0, 5,   0, RM_RNE, 23'h001000,   0,  4, 4'b0010); // 9
        add_vec(24'h800000, 3'b001, 0, 50,  0, RM_RUP, 23'h000001,  50,  0, 4'b0100); // 10
        add_vec(24'h800000, 3'b001, 0, 50,  0, RM_RDN, 23'h000000,  50,  0, 4'b0100); // 11
        add_vec(24'h800000, 3'b100, 0, 50,  0, RM_RMM, 23'h000001,  50,  0, 4'b0100); // 12
        add_vec(24'h800000, 3'b100, 0, 50,  0, RM_RNE, 23'h000000,  50,  0, 4'b0100); // 13
        add_vec(24'h800000, 3'b000, 1, 255, 0, RM_RTZ, 23'h7FFFFF, 254,  0, 4'b0101); // 14
        add_vec(24'h7FFFFF, 3'b100, 0, 1,   0, RM_RNE, 23'h000000,   1,  0, 4'b0100); // 15
        add_vec(24'h800001, 3'b100, 0, 50,  0, 3'b111, 23'h000002,  50,  0, 4'b0100); // 16

        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

endmodule
